// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared types and constants for the pipe_reg skid buffer.
// Holds the 2-bit FSM state encoding and the default payload width.
// No logic; imported by pipe_reg and pipe_reg_bank.
package pipe_reg_pkg;

  localparam int PIPE_REG_DEFAULT_WIDTH = 16;

  // EMPTY: nothing held; BUSY: main register valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage : pipe_reg_pkg

// File: rtl/pipe_reg_bank.sv
// pipe_reg_bank: WIDTH-bit data register with load enable.
// Latency: 1 cycle from i_load to o_q; holds o_q when i_load is low.
// Backpressure: none, the parent decides when to load.
// Ports: clk, rst (async active-low, loads RESET_VAL), i_load, i_d, o_q.
module pipe_reg_bank
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = PIPE_REG_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : pipe_reg_bank

// File: rtl/pipe_reg.sv
// pipe_reg: 2-entry valid/ready skid buffer (main + skid register), flushable.
// Latency: 1 cycle accept-to-out_valid; full throughput when streaming.
// Backpressure: in_ready is a flop, low only in FULL; out_data stable while stalled.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream), flush (sync squash),
//        err (X/Z on held state; live only when PIPE_REG_XCHECK_EN is defined,
//        otherwise tied low).
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = PIPE_REG_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic             err
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main;
  logic             w_load_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_comb begin
    w_next_state = r_state;
    w_load_main  = 1'b0;
    w_load_skid  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_next_state = ST_BUSY;
          w_load_main  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main = 1'b1;
        end else if (w_in_xfer) begin
          w_next_state = ST_FULL;
          w_load_skid  = 1'b1;
        end else if (w_out_xfer) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path can fire.
        if (w_out_xfer) begin
          w_next_state = ST_BUSY;
          w_load_main  = 1'b1;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
    // Flush discards any same-cycle accept; the data registers keep their
    // contents but become invisible once the state is EMPTY.
    if (flush) begin
      w_next_state = ST_EMPTY;
      w_load_main  = 1'b0;
      w_load_skid  = 1'b0;
    end
  end

  // Main is refilled from skid when draining FULL, otherwise from upstream.
  assign w_main_d = (r_state == ST_FULL) ? w_skid_q : in_data;

  // Handshake outputs are registered copies of the next state so that both
  // come straight from flops; in_ready stays low in reset and rises on the
  // first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != ST_FULL);
      r_out_valid <= (w_next_state != ST_EMPTY);
    end
  end

  pipe_reg_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load_main),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_reg_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load_skid),
    .i_d    (in_data),
    .o_q    (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;

`ifdef PIPE_REG_XCHECK_EN
  // Only entries that are currently valid are inspected; stale register
  // contents after a drain or flush are allowed to be anything.
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= $isunknown(r_state) | $isunknown(r_in_ready) | $isunknown(r_out_valid)
             | (r_out_valid & $isunknown(w_main_q))
             | ((r_state == ST_FULL) & $isunknown(w_skid_q));
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule : pipe_reg

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed self-checking bench for pipe_reg.
// Instances: 16-bit default build and an 8-bit build with RESET_VAL 0x5A.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_pipe_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flush;
  logic        err;

  logic        rst8;
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out_data8;
  logic        flush8;
  logic        err8;

  int checks;
  int errors;

  pipe_reg u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .err       (err)
  );

  pipe_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h5A)
  ) u_dut8 (
    .clk       (clk),
    .rst       (rst8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8),
    .flush     (flush8),
    .err       (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    step();
    step();
    #3;
    rst  = 1'b1;
    rst8 = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_pre_edge got %b exp 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL release_in_ready8 got %b exp 1", in_ready8); end
  endtask

  task automatic test_single();
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL single_out_data got %h exp 1234", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got valid=%b data=%h rdy=%b exp valid=1 data=%h rdy=1",
                 i, out_valid, out_data, in_ready, 16'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hAAAA;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_busy_in_ready got %b exp 1", in_ready); end
    in_data = 16'hBBBB;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
    checks++; if (out_data !== 16'hAAAA) begin errors++; $display("FAIL bp_full_data got %h exp aaaa", out_data); end
    // Offered while FULL: must be ignored.
    in_data = 16'hDDDD;
    step();
    checks++; if (out_data !== 16'hAAAA || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got valid=%b data=%h exp valid=1 data=aaaa", out_valid, out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got %b exp 0", in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hBBBB) begin errors++; $display("FAIL bp_second got valid=%b data=%h exp valid=1 data=bbbb", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_in_ready got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got %b exp 0", in_ready); end
    flush   = 1'b1;
    in_data = 16'hCCCC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_in_ready got %b exp 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d got %b exp 0", i, out_valid); end
    end
    // Flush in BUSY while an accept is offered: the accept is squashed.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h3333;
    step();
    flush   = 1'b1;
    in_data = 16'hCCCC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy_valid got %b exp 0", out_valid); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h4444;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h4444) begin errors++; $display("FAIL flush_recover got valid=%b data=%h exp valid=1 data=4444", out_valid, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_recover_drain got %b exp 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clean got %b exp 0", err); end
  endtask

  task automatic test_reset_mid();
    out_ready8 = 1'b0;
    in_valid8  = 1'b1;
    in_data8   = 8'h11;
    step();
    checks++; if (out_valid8 !== 1'b1 || out_data8 !== 8'h11) begin errors++; $display("FAIL mid_first got valid=%b data=%h exp valid=1 data=11", out_valid8, out_data8); end
    in_data8 = 8'h22;
    step();
    in_valid8 = 1'b0;
    #3;
    rst8 = 1'b0;
    #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid8); end
    checks++; if (out_data8 !== 8'h5A) begin errors++; $display("FAIL mid_rst_data got %h exp 5a", out_data8); end
    checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", in_ready8); end
    step();
    #3;
    rst8 = 1'b1;
    out_ready8 = 1'b1;
    step();
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b exp 1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0 || out_data8 !== 8'h5A) begin errors++; $display("FAIL mid_release_state got valid=%b data=%h exp valid=0 data=5a", out_valid8, out_data8); end
  endtask

`ifdef PIPE_REG_XCHECK_EN
  task automatic test_xcheck();
    logic seen;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hxxxx;
    step();
    in_valid = 1'b0;
    in_data  = 16'h0000;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL xcheck_advance got %b exp 1", out_valid); end
    seen = err;
    step();
    seen = seen | err;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL xcheck_err got %b exp 1", seen); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    rst8       = 1'b0;
    in_valid8  = 1'b0;
    in_data8   = '0;
    out_ready8 = 1'b0;
    flush8     = 1'b0;

    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef PIPE_REG_XCHECK_EN
    test_xcheck();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_reg
